uart_komut_surucu: RTL

//  Initiator end of the UART peripheral komut/veri interface: the core-side driver.

---
 rtl/uart_komut_surucu.sv | 125 ++++++++++++
 1 files changed

// File: rtl/uart_komut_surucu.sv
// Core-side UART driver: TX FIFO issuing one send command per byte, RX FIFO capturing
// received-byte pulses. Define UART_SURUCU_HATA_SAYAC_EN to add the dropped-byte counter hata_sayisi.
module uart_komut_surucu #(
  parameter int TX_DERINLIK = 8,
  parameter int RX_DERINLIK = 8,
  parameter int SAYI_W      = 4
) (
  input  logic              clk_g,
  input  logic              rst_g,
  input  logic [7:0]        gon_veri,
  input  logic              gon_gecerli,
  output logic              gon_hazir,
  output logic [7:0]        al_veri,
  output logic              al_gecerli,
  input  logic              al_hazir,
  output logic [31:0]       komut,
  output logic              komut_gecerli,
  input  logic              komut_hazir,
  input  logic [31:0]       veri,
  input  logic              veri_gecerli,
  output logic              veri_hazir,
  output logic [SAYI_W-1:0] tx_sayi,
  output logic [SAYI_W-1:0] rx_sayi,
  output logic              tasma,
  input  logic              tasma_temizle
`ifdef UART_SURUCU_HATA_SAYAC_EN
  ,
  output logic [7:0]        hata_sayisi
`endif
);
  localparam int TX_AW = $clog2(TX_DERINLIK);
  localparam int RX_AW = $clog2(RX_DERINLIK);

  logic [7:0]        r_tx_mem [TX_DERINLIK];
  logic [TX_AW-1:0]  r_tx_yaz, r_tx_oku;
  logic [SAYI_W-1:0] r_tx_sayi;
  logic [7:0]        r_rx_mem [RX_DERINLIK];
  logic [RX_AW-1:0]  r_rx_yaz, r_rx_oku;
  logic [SAYI_W-1:0] r_rx_sayi;
  logic              r_tasma;

  logic w_tx_dolu, w_tx_it, w_tx_cek;
  logic w_rx_dolu, w_rx_yaz, w_rx_cek, w_rx_dus;
  logic w_unused_veri;

  // Upper bytes of the peripheral data word carry nothing for this driver.
  assign w_unused_veri = ^veri[31:8];

  // ---------------- TX ----------------
  assign w_tx_dolu     = (r_tx_sayi == SAYI_W'(TX_DERINLIK));
  assign gon_hazir     = !w_tx_dolu;
  assign komut_gecerli = (r_tx_sayi != '0);
  assign w_tx_it       = gon_gecerli && gon_hazir;
  assign w_tx_cek      = komut_gecerli && komut_hazir;
  assign komut         = komut_gecerli ? {r_tx_mem[r_tx_oku], 21'b0, 3'b000} : 32'h0;
  assign tx_sayi       = r_tx_sayi;

  always_ff @(posedge clk_g) begin
    if (w_tx_it) r_tx_mem[r_tx_yaz] <= gon_veri;
  end

  always_ff @(posedge clk_g or negedge rst_g) begin
    if (!rst_g) begin
      r_tx_yaz  <= '0;
      r_tx_oku  <= '0;
      r_tx_sayi <= '0;
    end else begin
      if (w_tx_it)  r_tx_yaz <= r_tx_yaz + 1'b1;
      if (w_tx_cek) r_tx_oku <= r_tx_oku + 1'b1;
      case ({w_tx_it, w_tx_cek})
        2'b10:   r_tx_sayi <= r_tx_sayi + 1'b1;
        2'b01:   r_tx_sayi <= r_tx_sayi - 1'b1;
        default: r_tx_sayi <= r_tx_sayi;
      endcase
    end
  end

  // ---------------- RX ----------------
  // A full FIFO still takes a byte when the core pops in the same cycle.
  assign w_rx_dolu  = (r_rx_sayi == SAYI_W'(RX_DERINLIK));
  assign veri_hazir = !w_rx_dolu;
  assign al_gecerli = (r_rx_sayi != '0);
  assign w_rx_cek   = al_gecerli && al_hazir;
  assign w_rx_yaz   = veri_gecerli && (!w_rx_dolu || w_rx_cek);
  assign w_rx_dus   = veri_gecerli && w_rx_dolu && !w_rx_cek;
  assign al_veri    = al_gecerli ? r_rx_mem[r_rx_oku] : 8'h00;
  assign rx_sayi    = r_rx_sayi;
  assign tasma      = r_tasma;

  always_ff @(posedge clk_g) begin
    if (w_rx_yaz) r_rx_mem[r_rx_yaz] <= veri[7:0];
  end

  always_ff @(posedge clk_g or negedge rst_g) begin
    if (!rst_g) begin
      r_rx_yaz  <= '0;
      r_rx_oku  <= '0;
      r_rx_sayi <= '0;
      r_tasma   <= 1'b0;
    end else begin
      if (w_rx_yaz) r_rx_yaz <= r_rx_yaz + 1'b1;
      if (w_rx_cek) r_rx_oku <= r_rx_oku + 1'b1;
      case ({w_rx_yaz, w_rx_cek})
        2'b10:   r_rx_sayi <= r_rx_sayi + 1'b1;
        2'b01:   r_rx_sayi <= r_rx_sayi - 1'b1;
        default: r_rx_sayi <= r_rx_sayi;
      endcase
      if (w_rx_dus)           r_tasma <= 1'b1;
      else if (tasma_temizle) r_tasma <= 1'b0;
    end
  end

`ifdef UART_SURUCU_HATA_SAYAC_EN
  logic [7:0] r_hata;
  assign hata_sayisi = r_hata;

  // A drop in the clearing cycle still counts; the counter holds at 8'hFF.
  always_ff @(posedge clk_g or negedge rst_g) begin
    if (!rst_g)             r_hata <= 8'h00;
    else if (w_rx_dus)      r_hata <= (r_hata == 8'hFF) ? 8'hFF : r_hata + 8'h01;
    else if (tasma_temizle) r_hata <= 8'h00;
  end
`endif

endmodule
